z_stack: RTL and testbench

// - LIFO for neuron output vectors (z). Forward pass pushes one z vector per layer; backward pass

---
 rtl/z_stack_if.sv | 27 ++
 rtl/z_stack.sv | 119 +++++++++++
 tb/tb_z_stack.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/z_stack_if.sv
// Push/pop handshake bundle for z_stack. The forward-pass writer and error_fetcher reader
// connect through the master modport; the stack itself uses the slave modport.
interface z_stack_if #(
  parameter int unsigned NEURON_NUM          = 4,
  parameter int unsigned NEURON_OUTPUT_WIDTH = 10,
  parameter int unsigned LAYER_ADDR_WIDTH    = 2
);
  localparam int unsigned ZW = NEURON_NUM * NEURON_OUTPUT_WIDTH;

  logic [ZW-1:0]               z_in;
  logic                        z_in_valid;
  logic                        z_in_ready;
  logic [ZW-1:0]               z_out;
  logic                        z_out_valid;
  logic                        z_out_ready;
  logic [LAYER_ADDR_WIDTH-1:0] layer_out;

  modport master (
    output z_in, z_in_valid, z_out_ready,
    input  z_in_ready, z_out, z_out_valid, layer_out
  );

  modport slave (
    input  z_in, z_in_valid, z_out_ready,
    output z_in_ready, z_out, z_out_valid, layer_out
  );
endinterface

// File: rtl/z_stack.sv
// LIFO of z vectors: fills with one vector per layer, then drains them in reverse layer order.
// Optional macro Z_STACK_ERROR_EN adds a sticky error output for pushes attempted while draining.
module z_stack #(
  parameter int unsigned NEURON_NUM          = 4,
  parameter int unsigned NEURON_OUTPUT_WIDTH = 10,
  parameter int unsigned LAYER_ADDR_WIDTH    = 2,
  parameter int unsigned LAYER_MAX           = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  z_stack_if.slave                  zs,
  output logic [LAYER_ADDR_WIDTH:0] count
`ifdef Z_STACK_ERROR_EN
  ,
  output logic                      error
`endif
);
  localparam int unsigned ZW = NEURON_NUM * NEURON_OUTPUT_WIDTH;
  localparam int unsigned CW = LAYER_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CntLast = CW'(LAYER_MAX - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [LAYER_ADDR_WIDTH-1:0] LayerTop = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);

  typedef enum logic {StFill, StDrain} state_e;

  state_e                      state_q;
  logic [CW-1:0]               count_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [ZW-1:0]               z_out_q;
  logic [LAYER_ADDR_WIDTH-1:0] layer_q;
  logic [ZW-1:0]               mem [LAYER_MAX];

  logic push;
  logic pop;

  assign push = zs.z_in_valid & in_ready_q;
  assign pop  = zs.z_out_ready & out_valid_q;

  // Storage needs no reset; entries are only ever read below count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[count_q[LAYER_ADDR_WIDTH-1:0]] <= zs.z_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFill;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      z_out_q     <= '0;
      layer_q     <= '0;
    end else if (flush) begin
      state_q     <= StFill;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      z_out_q     <= '0;
      layer_q     <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (push) begin
            count_q <= count_q + CntOne;
            // Last push: mem write lands this edge, so present the incoming vector directly.
            if (count_q == CntLast) begin
              state_q     <= StDrain;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              z_out_q     <= zs.z_in;
              layer_q     <= LayerTop;
            end
          end
        end
        StDrain: begin
          if (pop) begin
            count_q <= count_q - CntOne;
            if (count_q == CntOne) begin
              state_q     <= StFill;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              z_out_q     <= '0;
              layer_q     <= '0;
            end else begin
              z_out_q <= mem[layer_q - 1'b1];
              layer_q <= layer_q - 1'b1;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

`ifdef Z_STACK_ERROR_EN
  logic error_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_q <= 1'b0;
    end else if (flush) begin
      error_q <= 1'b0;
    end else if (state_q == StDrain && zs.z_in_valid) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`endif

  assign zs.z_in_ready  = in_ready_q;
  assign zs.z_out_valid = out_valid_q;
  assign zs.z_out       = z_out_q;
  assign zs.layer_out   = layer_q;
  assign count          = count_q;
endmodule

// File: tb/tb_z_stack.sv
// Self-checking bench for z_stack against a queue-based LIFO model.
// Build with Z_STACK_ERROR_EN defined to also check the sticky error output.
module tb_z_stack;
  localparam int unsigned NN  = 4;
  localparam int unsigned NW  = 10;
  localparam int unsigned LAW = 2;
  localparam int unsigned LM  = 3;
  localparam int unsigned ZW  = NN * NW;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic [LAW:0] count;
`ifdef Z_STACK_ERROR_EN
  logic         error;
`endif

  z_stack_if #(.NEURON_NUM(NN), .NEURON_OUTPUT_WIDTH(NW), .LAYER_ADDR_WIDTH(LAW)) bus ();

  z_stack #(
    .NEURON_NUM(NN), .NEURON_OUTPUT_WIDTH(NW), .LAYER_ADDR_WIDTH(LAW), .LAYER_MAX(LM)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .zs    (bus),
    .count (count)
`ifdef Z_STACK_ERROR_EN
    ,
    .error (error)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: a queue whose back is the stack top, plus the fill/drain phase.
  logic [ZW-1:0] st[$];
  bit            draining = 1'b0;
  bit            err_m = 1'b0;

  function automatic logic [ZW-1:0] exp_z();
    return draining ? st[st.size()-1] : '0;
  endfunction

  function automatic logic [LAW-1:0] exp_layer();
    return draining ? LAW'(st.size() - 1) : '0;
  endfunction

  function automatic logic [ZW-1:0] vec(input int a, input int b, input int c, input int d);
    return {NW'(a), NW'(b), NW'(c), NW'(d)};
  endfunction

  function automatic logic [ZW-1:0] rand_vec();
    return {NW'($urandom), NW'($urandom), NW'($urandom), NW'($urandom)};
  endfunction

  // Drive one cycle of stimulus and advance the model across the rising edge.
  task automatic drive(input bit v, input logic [ZW-1:0] z, input bit r, input bit fl);
    bit was_drain;
    was_drain = draining;
    bus.z_in_valid = v;
    bus.z_in = z;
    bus.z_out_ready = r;
    flush = fl;
    @(posedge clk);
    if (fl) begin
      st.delete();
      draining = 1'b0;
    end else if (!draining && v) begin
      st.push_back(z);
      if (st.size() == LM) draining = 1'b1;
    end else if (draining && r) begin
      void'(st.pop_back());
      if (st.size() == 0) draining = 1'b0;
    end
    if (fl) err_m = 1'b0;
    else if (was_drain && v) err_m = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.z_in_valid = 1'b0;
    bus.z_in = '0;
    bus.z_out_ready = 1'b0;
    flush = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total += 5;
    if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    if (bus.z_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b", bus.z_in_ready); end
    if (bus.z_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b", bus.z_out_valid); end
    if (bus.layer_out !== 2'd0) begin bad++; $display("FAIL reset_layer got=%0d", bus.layer_out); end
    if (bus.z_out !== '0) begin bad++; $display("FAIL reset_z_out got=%h", bus.z_out); end
`ifdef Z_STACK_ERROR_EN
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b", error); end
`endif
    rst = 1'b1;
    st.delete();
    draining = 1'b0;
    err_m = 1'b0;
  endtask

  task automatic test_push_hold();
    drive(1'b1, vec(10, 20, 30, 40), 1'b0, 1'b0);
    drive(1'b1, vec(1, 2, 3, 4), 1'b0, 1'b0);
    drive(1'b1, vec(7, 7, 7, 7), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      total += 5;
      if (count !== 3'd3) begin bad++; $display("FAIL hold_count c%0d got=%0d want=3", i, count); end
      if (bus.z_in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready c%0d got=%b", i, bus.z_in_ready); end
      if (bus.z_out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c%0d got=%b", i, bus.z_out_valid); end
      if (bus.z_out !== vec(7, 7, 7, 7)) begin bad++; $display("FAIL hold_z c%0d got=%h", i, bus.z_out); end
      if (bus.layer_out !== 2'd2) begin bad++; $display("FAIL hold_layer c%0d got=%0d", i, bus.layer_out); end
      drive(1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_drain();
    logic [ZW-1:0] want_z [3];
    want_z[0] = vec(7, 7, 7, 7);
    want_z[1] = vec(1, 2, 3, 4);
    want_z[2] = vec(10, 20, 30, 40);
    for (int i = 0; i < 3; i++) begin
      total += 3;
      if (bus.z_out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid p%0d got=%b", i, bus.z_out_valid); end
      if (bus.z_out !== want_z[i]) begin bad++; $display("FAIL drain_z p%0d got=%h want=%h", i, bus.z_out, want_z[i]); end
      if (bus.layer_out !== LAW'(2 - i)) begin bad++; $display("FAIL drain_layer p%0d got=%0d want=%0d", i, bus.layer_out, 2 - i); end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    total += 4;
    if (bus.z_out_valid !== 1'b0) begin bad++; $display("FAIL drain_end_valid got=%b", bus.z_out_valid); end
    if (bus.z_in_ready !== 1'b1) begin bad++; $display("FAIL drain_end_ready got=%b", bus.z_in_ready); end
    if (count !== 3'd0) begin bad++; $display("FAIL drain_end_count got=%0d", count); end
    if (bus.z_out !== '0) begin bad++; $display("FAIL drain_end_z got=%h", bus.z_out); end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int round = 0; round < 8; round++) begin
      n = 0;
      while (n < 200 && (n == 0 || draining || st.size() != 0)) begin
        drive($urandom_range(0, 2) != 0, rand_vec(), $urandom_range(0, 1) != 0, 1'b0);
        n++;
        total += 5;
        if (count !== 3'(st.size())) begin bad++; $display("FAIL rnd_count r%0d n%0d got=%0d want=%0d", round, n, count, st.size()); end
        if (bus.z_in_ready !== !draining) begin bad++; $display("FAIL rnd_in_ready r%0d n%0d got=%b", round, n, bus.z_in_ready); end
        if (bus.z_out_valid !== draining) begin bad++; $display("FAIL rnd_valid r%0d n%0d got=%b", round, n, bus.z_out_valid); end
        if (bus.z_out !== exp_z()) begin bad++; $display("FAIL rnd_z r%0d n%0d got=%h want=%h", round, n, bus.z_out, exp_z()); end
        if (bus.layer_out !== exp_layer()) begin bad++; $display("FAIL rnd_layer r%0d n%0d got=%0d want=%0d", round, n, bus.layer_out, exp_layer()); end
`ifdef Z_STACK_ERROR_EN
        total++;
        if (error !== err_m) begin bad++; $display("FAIL rnd_error r%0d n%0d got=%b want=%b", round, n, error, err_m); end
`endif
      end
      total++;
      if (n >= 200) begin bad++; $display("FAIL rnd_timeout r%0d got=%0d cycles want<200", round, n); end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_flush_pop();
    for (int i = 0; i < 3; i++) drive(1'b1, rand_vec(), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    total += 2;
    if (count !== 3'd2) begin bad++; $display("FAIL fp_count1 got=%0d want=2", count); end
    if (bus.z_out !== exp_z()) begin bad++; $display("FAIL fp_z1 got=%h want=%h", bus.z_out, exp_z()); end
    drive(1'b0, '0, 1'b1, 1'b1);
    total += 5;
    if (count !== 3'd0) begin bad++; $display("FAIL fp_count got=%0d want=0", count); end
    if (bus.z_out_valid !== 1'b0) begin bad++; $display("FAIL fp_valid got=%b", bus.z_out_valid); end
    if (bus.z_in_ready !== 1'b1) begin bad++; $display("FAIL fp_ready got=%b", bus.z_in_ready); end
    if (bus.z_out !== '0) begin bad++; $display("FAIL fp_z got=%h", bus.z_out); end
    if (bus.layer_out !== 2'd0) begin bad++; $display("FAIL fp_layer got=%0d", bus.layer_out); end
    drive(1'b1, rand_vec(), 1'b0, 1'b0);
    total += 2;
    if (count !== 3'd1) begin bad++; $display("FAIL fp_refill_count got=%0d want=1", count); end
    if (bus.z_out_valid !== 1'b0) begin bad++; $display("FAIL fp_refill_valid got=%b", bus.z_out_valid); end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_push_in_drain();
    for (int i = 0; i < 3; i++) drive(1'b1, rand_vec(), 1'b0, 1'b0);
    drive(1'b1, rand_vec(), 1'b0, 1'b0);
    total += 2;
    if (count !== 3'd3) begin bad++; $display("FAIL pid_count got=%0d want=3", count); end
    if (bus.z_out !== exp_z()) begin bad++; $display("FAIL pid_z got=%h want=%h", bus.z_out, exp_z()); end
`ifdef Z_STACK_ERROR_EN
    total++;
    if (error !== 1'b1) begin bad++; $display("FAIL pid_error_set got=%b want=1", error); end
`endif
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.z_out !== exp_z()) begin bad++; $display("FAIL pid_drain_z p%0d got=%h want=%h", i, bus.z_out, exp_z()); end
      drive(1'b0, '0, 1'b1, 1'b0);
`ifdef Z_STACK_ERROR_EN
      total++;
      if (error !== 1'b1) begin bad++; $display("FAIL pid_error_hold p%0d got=%b", i, error); end
`endif
    end
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL pid_end_count got=%0d", count); end
    drive(1'b0, '0, 1'b0, 1'b1);
`ifdef Z_STACK_ERROR_EN
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL pid_error_flush got=%b want=0", error); end
`endif
  endtask

  task automatic test_reset_mid();
    drive(1'b1, rand_vec(), 1'b0, 1'b0);
    drive(1'b1, rand_vec(), 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    total += 3;
    if (count !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", count); end
    if (bus.z_in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b", bus.z_in_ready); end
    if (bus.z_out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b", bus.z_out_valid); end
    st.delete();
    draining = 1'b0;
    err_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, rand_vec(), 1'b0, 1'b0);
    total++;
    if (count !== 3'd1) begin bad++; $display("FAIL rmid_after_count got=%0d want=1", count); end
  endtask

  initial begin
    test_reset();
    test_push_hold();
    test_drain();
    test_random();
    test_flush_pop();
    test_push_in_drain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
